// File: rtl/pic_rw_sequencer.sv
// 8259 CPU bus front end: synchronises the strobes, tracks ICW1..ICW4, classifies OCW1..3.
// Optional sticky illegal-write flag enabled by PIC_RW_INIT_ERR_EN.
//
// state      | meaning
// UNINIT     | after reset, only ICW1 is accepted
// WAIT_ICW2  | ICW1 seen, expecting vector base (A0=1)
// WAIT_ICW3  | cascade mode, expecting slave/master id (A0=1)
// WAIT_ICW4  | IC4 set, expecting mode word (A0=1)
// READY      | initialised, OCW1/2/3 accepted
module pic_rw_sequencer #(
  parameter int          SYNC_STAGES = 2,
  parameter logic [2:0]  FLAG_IDLE   = 3'b111
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CS_n,
  input  logic       WR_n,
  input  logic       RD_n,
  input  logic       A0,
  input  logic [7:0] D_in,
  output logic [2:0] FlagFromRW,
  output logic [7:0] ReadWriteinputData,
  output logic [2:0] read2controlRW,
  output logic       init_done,
  output logic       init_err
);

  localparam logic [2:0] UNINIT    = 3'd0;
  localparam logic [2:0] WAIT_ICW2 = 3'd1;
  localparam logic [2:0] WAIT_ICW3 = 3'd2;
  localparam logic [2:0] WAIT_ICW4 = 3'd3;
  localparam logic [2:0] READY     = 3'd4;

  localparam logic [2:0] F_ICW1 = 3'd0;
  localparam logic [2:0] F_ICW2 = 3'd1;
  localparam logic [2:0] F_ICW3 = 3'd2;
  localparam logic [2:0] F_ICW4 = 3'd3;
  localparam logic [2:0] F_OCW1 = 3'd4;
  localparam logic [2:0] F_OCW2 = 3'd5;
  localparam logic [2:0] F_OCW3 = 3'd6;

  logic [SYNC_STAGES-1:0] cs_sync, wr_sync, rd_sync, a0_sync;
  logic       s_cs, s_wr, s_rd, s_a0;
  logic       wr_prev;
  logic [7:0] pend_data;
  logic       pend_a0, pend_valid;
  logic [2:0] state, nxt_state, nxt_flag;
  logic       sngl, ic4, ris;
  logic       nxt_sngl, nxt_ic4, nxt_ris;
  logic       accept, is_icw1, commit;

  assign s_cs   = cs_sync[SYNC_STAGES-1];
  assign s_wr   = wr_sync[SYNC_STAGES-1];
  assign s_rd   = rd_sync[SYNC_STAGES-1];
  assign s_a0   = a0_sync[SYNC_STAGES-1];
  assign commit = s_wr && !wr_prev && pend_valid;
  assign init_done = (state == READY);

  // ICW1 is recognised first so it restarts initialisation from any state.
  always_comb begin
    accept    = 1'b0;
    is_icw1   = 1'b0;
    nxt_flag  = FLAG_IDLE;
    nxt_state = state;
    nxt_sngl  = sngl;
    nxt_ic4   = ic4;
    nxt_ris   = ris;
    if (!pend_a0 && pend_data[4]) begin
      accept    = 1'b1;
      is_icw1   = 1'b1;
      nxt_flag  = F_ICW1;
      nxt_state = WAIT_ICW2;
      nxt_sngl  = pend_data[1];
      nxt_ic4   = pend_data[0];
      nxt_ris   = 1'b0;
    end else begin
      case (state)
        WAIT_ICW2: if (pend_a0) begin
          accept    = 1'b1;
          nxt_flag  = F_ICW2;
          nxt_state = !sngl ? WAIT_ICW3 : (ic4 ? WAIT_ICW4 : READY);
        end
        WAIT_ICW3: if (pend_a0) begin
          accept    = 1'b1;
          nxt_flag  = F_ICW3;
          nxt_state = ic4 ? WAIT_ICW4 : READY;
        end
        WAIT_ICW4: if (pend_a0) begin
          accept    = 1'b1;
          nxt_flag  = F_ICW4;
          nxt_state = READY;
        end
        READY: begin
          accept = 1'b1;
          if (pend_a0)           nxt_flag = F_OCW1;
          else if (!pend_data[3]) nxt_flag = F_OCW2;
          else begin
            nxt_flag = F_OCW3;
            if (pend_data[1]) nxt_ris = pend_data[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync            <= '1;
      wr_sync            <= '1;
      rd_sync            <= '1;
      a0_sync            <= '0;
      wr_prev            <= 1'b1;
      pend_data          <= 8'h00;
      pend_a0            <= 1'b0;
      pend_valid         <= 1'b0;
      state              <= UNINIT;
      sngl               <= 1'b0;
      ic4                <= 1'b0;
      ris                <= 1'b0;
      FlagFromRW         <= FLAG_IDLE;
      ReadWriteinputData <= 8'h00;
      read2controlRW     <= 3'b000;
    end else begin
      cs_sync[0] <= CS_n;
      wr_sync[0] <= WR_n;
      rd_sync[0] <= RD_n;
      a0_sync[0] <= A0;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cs_sync[i] <= cs_sync[i-1];
        wr_sync[i] <= wr_sync[i-1];
        rd_sync[i] <= rd_sync[i-1];
        a0_sync[i] <= a0_sync[i-1];
      end
      wr_prev    <= s_wr;
      FlagFromRW <= FLAG_IDLE;
      if (!s_wr && !s_cs) begin
        pend_data  <= D_in;
        pend_a0    <= s_a0;
        pend_valid <= 1'b1;
      end else if (commit) begin
        pend_valid <= 1'b0;
        if (accept) begin
          FlagFromRW         <= nxt_flag;
          ReadWriteinputData <= pend_data;
          state              <= nxt_state;
          sngl               <= nxt_sngl;
          ic4                <= nxt_ic4;
          ris                <= nxt_ris;
        end
      end
      // A concurrent write strobe suppresses the read select.
      if (!s_cs && !s_rd && s_wr && state == READY)
        read2controlRW <= s_a0 ? 3'b011 : {ris, 2'b01};
      else
        read2controlRW <= 3'b000;
    end
  end

`ifdef PIC_RW_INIT_ERR_EN
  always_ff @(posedge clk) begin
    if (reset)                   init_err <= 1'b0;
    else if (commit && is_icw1)  init_err <= 1'b0;
    else if (commit && !accept)  init_err <= 1'b1;
  end
`else
  assign init_err = 1'b0;
`endif

endmodule

// File: tb/tb_pic_rw_sequencer.sv
// Directed bench for pic_rw_sequencer: init sequences, OCW decode, read select, reset.
module tb_pic_rw_sequencer;
  localparam logic [2:0] IDLE = 3'b111;
  localparam int EXP_LAT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1, A0 = 1'b0;
  logic [7:0] D_in = 8'h00;
  logic [2:0] FlagFromRW;
  logic [7:0] ReadWriteinputData;
  logic [2:0] read2controlRW;
  logic       init_done, init_err;

  int n_checks = 0;
  int n_pass   = 0;

  pic_rw_sequencer dut (
    .clk(clk), .reset(reset), .CS_n(CS_n), .WR_n(WR_n), .RD_n(RD_n), .A0(A0),
    .D_in(D_in), .FlagFromRW(FlagFromRW), .ReadWriteinputData(ReadWriteinputData),
    .read2controlRW(read2controlRW), .init_done(init_done), .init_err(init_err)
  );

  always #5 clk = ~clk;

  // Performs one CPU write and watches a bounded window for the flag pulse.
  task automatic do_write(input logic a, input logic [7:0] d,
                          output logic [2:0] flag, output int lat, output int width);
    flag = IDLE; lat = 0; width = 0;
    @(negedge clk); A0 = a; D_in = d; CS_n = 1'b0; WR_n = 1'b0;
    repeat (4) @(negedge clk);
    WR_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (FlagFromRW !== IDLE) begin
        if (width == 0) begin flag = FlagFromRW; lat = c; end
        width++;
      end
    end
    CS_n = 1'b1;
  endtask

  task automatic do_read(input logic a, output logic [2:0] sel);
    @(negedge clk); A0 = a; CS_n = 1'b0; RD_n = 1'b0;
    repeat (4) @(negedge clk);
    sel = read2controlRW;
    RD_n = 1'b1; CS_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk); reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] sel;
    apply_reset();
    n_checks++; if (FlagFromRW !== IDLE) $display("FAIL reset_flag got %0d want 7", FlagFromRW); else n_pass++;
    n_checks++; if (ReadWriteinputData !== 8'h00) $display("FAIL reset_data got %h want 00", ReadWriteinputData); else n_pass++;
    n_checks++; if (read2controlRW !== 3'b000) $display("FAIL reset_read got %b want 000", read2controlRW); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL reset_done got %b want 0", init_done); else n_pass++;
    n_checks++; if (init_err !== 1'b0) $display("FAIL reset_err got %b want 0", init_err); else n_pass++;
    do_read(1'b0, sel);
    n_checks++; if (sel !== 3'b000) $display("FAIL uninit_read got %b want 000", sel); else n_pass++;
  endtask

  task automatic test_single();
    logic [2:0] f; int lat, w;
    do_write(1'b0, 8'h13, f, lat, w);
    n_checks++; if (f !== 3'd0) $display("FAIL single_icw1 got %0d want 0", f); else n_pass++;
    n_checks++; if (lat != EXP_LAT) $display("FAIL single_latency got %0d want %0d", lat, EXP_LAT); else n_pass++;
    n_checks++; if (w != 1) $display("FAIL single_width got %0d want 1", w); else n_pass++;
    do_write(1'b1, 8'h20, f, lat, w);
    n_checks++; if (f !== 3'd1 || w != 1) $display("FAIL single_icw2 got %0d/%0d want 1/1", f, w); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL single_done_mid got %b want 0", init_done); else n_pass++;
    do_write(1'b1, 8'h01, f, lat, w);
    n_checks++; if (f !== 3'd3 || w != 1) $display("FAIL single_icw4 got %0d/%0d want 3/1", f, w); else n_pass++;
    n_checks++; if (init_done !== 1'b1) $display("FAIL single_done got %b want 1", init_done); else n_pass++;
  endtask

  task automatic test_cascade();
    logic [2:0] f; int lat, w;
    do_write(1'b0, 8'h10, f, lat, w);
    n_checks++; if (f !== 3'd0) $display("FAIL cascade_icw1 got %0d want 0", f); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL restart_done got %b want 0", init_done); else n_pass++;
    do_write(1'b1, 8'h08, f, lat, w);
    n_checks++; if (f !== 3'd1) $display("FAIL cascade_icw2 got %0d want 1", f); else n_pass++;
    do_write(1'b1, 8'h04, f, lat, w);
    n_checks++; if (f !== 3'd2) $display("FAIL cascade_icw3 got %0d want 2", f); else n_pass++;
    n_checks++; if (init_done !== 1'b1) $display("FAIL cascade_done got %b want 1", init_done); else n_pass++;
    do_write(1'b1, 8'hFB, f, lat, w);
    n_checks++; if (f !== 3'd4) $display("FAIL ocw1_flag got %0d want 4", f); else n_pass++;
    n_checks++; if (ReadWriteinputData !== 8'hFB) $display("FAIL ocw1_data got %h want fb", ReadWriteinputData); else n_pass++;
  endtask

  task automatic test_read();
    logic [2:0] f, sel; int lat, w;
    do_write(1'b0, 8'h0B, f, lat, w);
    n_checks++; if (f !== 3'd6) $display("FAIL ocw3_flag got %0d want 6", f); else n_pass++;
    do_read(1'b0, sel);
    n_checks++; if (sel !== 3'b101) $display("FAIL read_isr got %b want 101", sel); else n_pass++;
    do_read(1'b1, sel);
    n_checks++; if (sel !== 3'b011) $display("FAIL read_imr got %b want 011", sel); else n_pass++;
    do_write(1'b0, 8'h0A, f, lat, w);
    do_read(1'b0, sel);
    n_checks++; if (sel !== 3'b001) $display("FAIL read_irr got %b want 001", sel); else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [2:0] f, sel; int w;
    f = IDLE; w = 0;
    @(negedge clk); A0 = 1'b1; D_in = 8'hAA; CS_n = 1'b0; WR_n = 1'b0; RD_n = 1'b0;
    repeat (4) @(negedge clk);
    sel = read2controlRW;
    WR_n = 1'b1; RD_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (FlagFromRW !== IDLE) begin if (w == 0) f = FlagFromRW; w++; end
    end
    CS_n = 1'b1;
    n_checks++; if (sel !== 3'b000) $display("FAIL simul_read got %b want 000", sel); else n_pass++;
    n_checks++; if (f !== 3'd4 || w != 1) $display("FAIL simul_flag got %0d/%0d want 4/1", f, w); else n_pass++;
    n_checks++; if (ReadWriteinputData !== 8'hAA) $display("FAIL simul_data got %h want aa", ReadWriteinputData); else n_pass++;
  endtask

  task automatic test_ocw2();
    logic [2:0] f; int lat, w;
    logic exp_err;
`ifdef PIC_RW_INIT_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_write(1'b0, 8'h20, f, lat, w);
    n_checks++; if (f !== 3'd5 || w != 1) $display("FAIL ocw2_flag got %0d/%0d want 5/1", f, w); else n_pass++;
    apply_reset();
    do_write(1'b0, 8'h20, f, lat, w);
    n_checks++; if (f !== IDLE) $display("FAIL uninit_reject got %0d want 7", f); else n_pass++;
    n_checks++; if (ReadWriteinputData !== 8'h00) $display("FAIL reject_data got %h want 00", ReadWriteinputData); else n_pass++;
    n_checks++; if (init_err !== exp_err) $display("FAIL init_err got %b want %b", init_err, exp_err); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [2:0] f; int lat, w;
    do_write(1'b0, 8'h10, f, lat, w);
    do_write(1'b1, 8'h08, f, lat, w);
    n_checks++; if (f !== 3'd1) $display("FAIL mid_icw2 got %0d want 1", f); else n_pass++;
    apply_reset();
    n_checks++; if (init_done !== 1'b0) $display("FAIL mid_done got %b want 0", init_done); else n_pass++;
    n_checks++; if (init_err !== 1'b0) $display("FAIL mid_err got %b want 0", init_err); else n_pass++;
    do_write(1'b1, 8'h04, f, lat, w);
    n_checks++; if (f !== IDLE) $display("FAIL mid_noflag got %0d want 7", f); else n_pass++;
    n_checks++; if (init_done !== 1'b0) $display("FAIL mid_done2 got %b want 0", init_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_cascade();
    test_read();
    test_simultaneous();
    test_ocw2();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
